// File: rtl/ul8_register.sv
// Loadable UL8 datapath register: captures data_in on a rising clk edge when load is high, else holds.
// One-edge load latency, no backpressure; define UL8_REGISTER_CLR_EN to add a synchronous clr with priority over load.
module ul8_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
`ifdef UL8_REGISTER_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;

  // Clear outranks load; with neither asserted the word is held.
  always_comb begin
    w_next = r_data;
`ifdef UL8_REGISTER_CLR_EN
    if (clr) begin
      w_next = RESET_VALUE;
    end else if (load) begin
      w_next = data_in;
    end
`else
    if (load) begin
      w_next = data_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= RESET_VALUE;
    end else begin
      r_data <= w_next;
    end
  end

  assign data_out = r_data;

endmodule

// File: tb/tb_ul8_register.sv
// Randomised and directed bench for ul8_register against a behavioural expected-word model.
`timescale 1ns/100ps
module tb_ul8_register;

  localparam logic [7:0] RST_VAL = 8'h00;

  logic       clk;
  logic       resetn;
  logic [7:0] data_in;
  logic       load;
`ifdef UL8_REGISTER_CLR_EN
  logic       clr;
`endif
  logic [7:0] data_out;

  int errors;
  int checks;
  logic [7:0] exp_q;

  ul8_register #(.WIDTH(8), .RESET_VALUE(RST_VAL)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (data_in),
    .load     (load),
`ifdef UL8_REGISTER_CLR_EN
    .clr      (clr),
`endif
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    resetn  = 1'b0;
    load    = 1'b0;
    data_in = 8'hFF;
`ifdef UL8_REGISTER_CLR_EN
    clr     = 1'b0;
`endif
    #1;
    checks++;
    if (data_out !== RST_VAL) begin
      errors++;
      $display("FAIL reset_asserted: got %h want %h", data_out, RST_VAL);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_q  = RST_VAL;
    @(posedge clk); #1;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", data_out, exp_q);
    end
  endtask

  task automatic test_basic_load();
    @(negedge clk);
    data_in = 8'hFF;
    load    = 1'b1;
    @(posedge clk); #1;
    exp_q = 8'hFF;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL basic_load: got %h want %h", data_out, exp_q);
    end
    @(negedge clk);
    load    = 1'b0;
    data_in = 8'h12;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp_q) begin
        errors++;
        $display("FAIL basic_hold[%0d]: got %h want %h", i, data_out, exp_q);
      end
      @(negedge clk);
      data_in = 8'(data_in + 8'h11);
    end
  endtask

  task automatic test_sample_point();
    @(negedge clk);
    data_in = 8'hFF;
    load    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 8'hAB;
    #1;
    checks++;
    if (data_out !== 8'hFF) begin
      errors++;
      $display("FAIL sample_between_edges: got %h want %h", data_out, 8'hFF);
    end
    @(posedge clk); #1;
    exp_q = 8'hAB;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL sample_next_edge: got %h want %h", data_out, exp_q);
    end
  endtask

  task automatic test_same_step();
    // The change lands in the edge's own time step, after the flop has sampled.
    @(posedge clk);
    data_in <= 8'hBA;
    #1;
    checks++;
    if (data_out !== 8'hAB) begin
      errors++;
      $display("FAIL same_step_old: got %h want %h", data_out, 8'hAB);
    end
    @(posedge clk); #1;
    exp_q = 8'hBA;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL same_step_new: got %h want %h", data_out, exp_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    data_in = 8'hAB;
    load    = 1'b1;
    @(posedge clk);
    #0.5;
    checks++;
    if (data_out !== 8'hAB) begin
      errors++;
      $display("FAIL async_pre: got %h want %h", data_out, 8'hAB);
    end
    #0.5;
    resetn  = 1'b0;
    data_in = 8'h55;
    #0.9;
    exp_q = RST_VAL;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL async_immediate: got %h want %h", data_out, exp_q);
    end
    @(posedge clk); #1;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL async_held: got %h want %h", data_out, exp_q);
    end
    @(negedge clk);
    load   = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL async_release: got %h want %h", data_out, exp_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[$];
    vals = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h3C};
    @(negedge clk);
    load = 1'b1;
    foreach (vals[i]) begin
      data_in = vals[i];
      @(posedge clk); #1;
      exp_q = vals[i];
      checks++;
      if (data_out !== exp_q) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, data_out, exp_q);
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

`ifdef UL8_REGISTER_CLR_EN
  task automatic test_clear();
    @(negedge clk);
    data_in = 8'h5A;
    load    = 1'b1;
    clr     = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (data_out !== 8'h5A) begin
      errors++;
      $display("FAIL clear_setup: got %h want %h", data_out, 8'h5A);
    end
    @(negedge clk);
    data_in = 8'h33;
    clr     = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (data_out !== RST_VAL) begin
      errors++;
      $display("FAIL clear_priority: got %h want %h", data_out, RST_VAL);
    end
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    exp_q = 8'h33;
    checks++;
    if (data_out !== exp_q) begin
      errors++;
      $display("FAIL clear_then_load: got %h want %h", data_out, exp_q);
    end
    @(negedge clk);
    load = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic       l;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      l = 1'($urandom_range(0, 1));
      data_in = d;
      load    = l;
`ifdef UL8_REGISTER_CLR_EN
      clr = ($urandom_range(0, 7) == 0);
      if (clr) exp_q = RST_VAL;
      else if (l) exp_q = d;
`else
      if (l) exp_q = d;
`endif
      // Glitch data_in mid-cycle; only the pre-edge value should matter.
      #2;
      data_in = ~d;
      #2;
      data_in = d;
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp_q) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, data_out, exp_q);
      end
      @(negedge clk);
    end
    load = 1'b0;
`ifdef UL8_REGISTER_CLR_EN
    clr = 1'b0;
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_q  = RST_VAL;
    test_reset();
    test_basic_load();
    test_sample_point();
    test_same_step();
    test_async_reset();
    test_back_to_back();
`ifdef UL8_REGISTER_CLR_EN
    test_clear();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
